// File: rtl/player_move_controller.sv
// Player sprite position owner: gates move requests, animates one cell per move, waits for the detector to settle.
// Optional MOVE_QUEUE_EN: buffers one request seen while busy and replays it in the first IDLE cycle.
module player_move_controller #(
   parameter int ORIGIN_X   = 336,
   parameter int ORIGIN_Y   = 27,
   parameter int CELL_PX    = 16,
   parameter int CENTER_OFF = 7,
   parameter int GRID_W     = 16,
   parameter int GRID_H     = 16,
   parameter int START_COL  = 1,
   parameter int START_ROW  = 1,
   parameter int STEP_DIV   = 100000,
   parameter int DETECT_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        move_req,
   input  logic [1:0]  move_dir,
   input  logic [3:0]  valid_moves,
   output logic [10:0] curr_pos_x,
   output logic [9:0]  curr_pos_y,
   output logic [3:0]  cell_col,
   output logic [3:0]  cell_row,
   output logic        busy,
   output logic        move_done,
   output logic        move_rejected
);

   localparam int PW  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int PXW = $clog2(CELL_PX) + 1;
   localparam int DLW = (DETECT_LAT > 0) ? $clog2(DETECT_LAT + 1) : 1;

   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_DOWN  = 2'b01;
   localparam logic [1:0] DIR_LEFT  = 2'b10;
   localparam logic [1:0] DIR_RIGHT = 2'b11;

   typedef enum logic [1:0] {IDLE, MOVE, SETTLE} state_t;

   function automatic logic [10:0] cell_x(input logic [3:0] c);
      return 11'(ORIGIN_X + int'(c) * CELL_PX + CENTER_OFF);
   endfunction

   function automatic logic [9:0] cell_y(input logic [3:0] r);
      return 10'(ORIGIN_Y + int'(r) * CELL_PX + CENTER_OFF);
   endfunction

   function automatic logic in_bounds(input logic [1:0] d, input logic [3:0] c, input logic [3:0] r);
      case (d)
         DIR_UP:   return r != 4'd0;
         DIR_DOWN: return int'(r) < GRID_H - 1;
         DIR_LEFT: return c != 4'd0;
         default:  return int'(c) < GRID_W - 1;
      endcase
   endfunction

   state_t           state_q;
   logic [DLW-1:0]   settle_q;
   logic [PW-1:0]    presc_q;
   logic [PXW-1:0]   pix_q;
   logic [1:0]       dir_q;
   logic [3:0]       col_q, row_q;
   logic [10:0]      pos_x_q;
   logic [9:0]       pos_y_q;
   logic             busy_q, done_q, rej_q;
   logic             req_d, ok_d;
   logic [1:0]       dir_d;

`ifdef MOVE_QUEUE_EN
   logic             pend_vld_q;
   logic [1:0]       pend_dir_q;
`endif

   // A live request wins over a buffered one; the bit index of valid_moves is the inverted direction code.
   always_comb begin
      req_d = 1'b0;
      dir_d = move_dir;
      if (move_req) begin
         req_d = 1'b1;
         dir_d = move_dir;
      end
`ifdef MOVE_QUEUE_EN
      else if (pend_vld_q) begin
         req_d = 1'b1;
         dir_d = pend_dir_q;
      end
`endif
      ok_d = valid_moves[~dir_d] && in_bounds(dir_d, col_q, row_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= SETTLE;
         settle_q <= DLW'(DETECT_LAT);
         presc_q  <= '0;
         pix_q    <= '0;
         dir_q    <= DIR_UP;
         col_q    <= 4'(START_COL);
         row_q    <= 4'(START_ROW);
         pos_x_q  <= cell_x(4'(START_COL));
         pos_y_q  <= cell_y(4'(START_ROW));
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         rej_q    <= 1'b0;
`ifdef MOVE_QUEUE_EN
         pend_vld_q <= 1'b0;
         pend_dir_q <= DIR_UP;
`endif
      end else begin
         done_q <= 1'b0;
         rej_q  <= 1'b0;
`ifdef MOVE_QUEUE_EN
         if (state_q != IDLE) begin
            if (move_req) begin
               pend_vld_q <= 1'b1;
               pend_dir_q <= move_dir;
            end
         end else begin
            pend_vld_q <= 1'b0;
         end
`endif
         case (state_q)
            IDLE: begin
               if (req_d) begin
                  if (ok_d) begin
                     dir_q   <= dir_d;
                     presc_q <= '0;
                     pix_q   <= '0;
                     state_q <= MOVE;
                     busy_q  <= 1'b1;
                  end else begin
                     rej_q <= 1'b1;
                  end
               end
            end
            MOVE: begin
               if (presc_q == PW'(STEP_DIV - 1)) begin
                  presc_q <= '0;
                  pix_q   <= pix_q + 1'b1;
                  case (dir_q)
                     DIR_UP:   pos_y_q <= pos_y_q - 10'd1;
                     DIR_DOWN: pos_y_q <= pos_y_q + 10'd1;
                     DIR_LEFT: pos_x_q <= pos_x_q - 11'd1;
                     default:  pos_x_q <= pos_x_q + 11'd1;
                  endcase
                  // Last pixel of the cell: commit the cell index and start settling.
                  if (pix_q == PXW'(CELL_PX - 1)) begin
                     case (dir_q)
                        DIR_UP:   row_q <= row_q - 4'd1;
                        DIR_DOWN: row_q <= row_q + 4'd1;
                        DIR_LEFT: col_q <= col_q - 4'd1;
                        default:  col_q <= col_q + 4'd1;
                     endcase
                     done_q <= 1'b1;
                     if (DETECT_LAT == 0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                     end else begin
                        state_q  <= SETTLE;
                        settle_q <= DLW'(DETECT_LAT - 1);
                     end
                  end
               end else begin
                  presc_q <= presc_q + 1'b1;
               end
            end
            SETTLE: begin
               if (settle_q == '0) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  settle_q <= settle_q - 1'b1;
                  busy_q   <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign curr_pos_x    = pos_x_q;
   assign curr_pos_y    = pos_y_q;
   assign cell_col      = col_q;
   assign cell_row      = row_q;
   assign busy          = busy_q;
   assign move_done     = done_q;
   assign move_rejected = rej_q;

endmodule

// File: tb/tb_player_move_controller.sv
// Directed bench for player_move_controller with STEP_DIV=2, DETECT_LAT=2; honours MOVE_QUEUE_EN if defined.
module tb_player_move_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        move_req;
   logic [1:0]  move_dir;
   logic [3:0]  valid_moves;
   logic [10:0] curr_pos_x;
   logic [9:0]  curr_pos_y;
   logic [3:0]  cell_col;
   logic [3:0]  cell_row;
   logic        busy;
   logic        move_done;
   logic        move_rejected;

   int n_checks = 0;
   int n_pass   = 0;

   player_move_controller #(.STEP_DIV(2), .DETECT_LAT(2)) dut (
      .clk(clk), .rst(rst), .move_req(move_req), .move_dir(move_dir),
      .valid_moves(valid_moves), .curr_pos_x(curr_pos_x), .curr_pos_y(curr_pos_y),
      .cell_col(cell_col), .cell_row(cell_row), .busy(busy),
      .move_done(move_done), .move_rejected(move_rejected)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int done_wait = 0;
      for (int i = 0; i < 200; i++) begin
         if (!busy) begin
            done_wait = 1;
            break;
         end
         tick();
      end
      if (done_wait == 0) begin
         n_checks++;
         $display("FAIL wait_idle: busy=%0b still after 200 cycles, required 0", busy);
      end
   endtask

   task automatic do_move(input logic [1:0] d, input logic [3:0] vm);
      valid_moves = vm;
      move_dir    = d;
      move_req    = 1'b1;
      tick();
      move_req = 1'b0;
      wait_idle();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      n_checks++; if (curr_pos_x !== 11'd359) $display("FAIL reset_x: got %0d want 359", curr_pos_x); else n_pass++;
      n_checks++; if (curr_pos_y !== 10'd50) $display("FAIL reset_y: got %0d want 50", curr_pos_y); else n_pass++;
      n_checks++; if ({cell_col, cell_row} !== 8'h11) $display("FAIL reset_cell: got %0d/%0d want 1/1", cell_col, cell_row); else n_pass++;
      n_checks++; if ({busy, move_done, move_rejected} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy, move_done, move_rejected}); else n_pass++;
      rst = 1'b0;
      tick();
      n_checks++; if (busy !== 1'b1) $display("FAIL reset_settle1: busy=%b want 1", busy); else n_pass++;
      tick();
      n_checks++; if (busy !== 1'b1) $display("FAIL reset_settle2: busy=%b want 1", busy); else n_pass++;
      tick();
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_settle_end: busy=%b want 0", busy); else n_pass++;
   endtask

   task automatic test_move_right();
      valid_moves = 4'b0001;
      move_dir    = 2'b11;
      move_req    = 1'b1;
      tick();
      move_req = 1'b0;
      n_checks++; if (busy !== 1'b1 || curr_pos_x !== 11'd359) $display("FAIL right_start: busy=%b x=%0d want 1 359", busy, curr_pos_x); else n_pass++;
      tick();
      tick();
      n_checks++; if (curr_pos_x !== 11'd360) $display("FAIL right_first_px: x=%0d want 360", curr_pos_x); else n_pass++;
      repeat (29) tick();
      n_checks++; if (curr_pos_x !== 11'd374 || move_done !== 1'b0 || cell_col !== 4'd1) $display("FAIL right_A31: x=%0d done=%b col=%0d want 374 0 1", curr_pos_x, move_done, cell_col); else n_pass++;
      tick();
      n_checks++; if (curr_pos_x !== 11'd375 || cell_col !== 4'd2 || move_done !== 1'b1 || curr_pos_y !== 10'd50) $display("FAIL right_done: x=%0d col=%0d done=%b y=%0d want 375 2 1 50", curr_pos_x, cell_col, move_done, curr_pos_y); else n_pass++;
      tick();
      n_checks++; if (move_done !== 1'b0 || busy !== 1'b1) $display("FAIL right_settle: done=%b busy=%b want 0 1", move_done, busy); else n_pass++;
      tick();
      n_checks++; if (busy !== 1'b0) $display("FAIL right_busy_fall: busy=%b want 0", busy); else n_pass++;
   endtask

   task automatic test_reject_valid();
      do_move(2'b10, 4'b0010);
      n_checks++; if (curr_pos_x !== 11'd359 || cell_col !== 4'd1) $display("FAIL back_left: x=%0d col=%0d want 359 1", curr_pos_x, cell_col); else n_pass++;
      valid_moves = 4'b1110;
      move_dir    = 2'b11;
      move_req    = 1'b1;
      tick();
      move_req = 1'b0;
      n_checks++; if (move_rejected !== 1'b1 || busy !== 1'b0 || move_done !== 1'b0) $display("FAIL reject_valid: rej=%b busy=%b done=%b want 1 0 0", move_rejected, busy, move_done); else n_pass++;
      tick();
      n_checks++; if (move_rejected !== 1'b0 || busy !== 1'b0 || curr_pos_x !== 11'd359) $display("FAIL reject_valid_after: rej=%b busy=%b x=%0d want 0 0 359", move_rejected, busy, curr_pos_x); else n_pass++;
   endtask

   task automatic test_bounds();
      do_move(2'b10, 4'b1111);
      n_checks++; if (curr_pos_x !== 11'd343 || cell_col !== 4'd0) $display("FAIL to_col0: x=%0d col=%0d want 343 0", curr_pos_x, cell_col); else n_pass++;
      valid_moves = 4'b1111;
      move_dir    = 2'b10;
      move_req    = 1'b1;
      tick();
      move_req = 1'b0;
      n_checks++; if (move_rejected !== 1'b1 || busy !== 1'b0) $display("FAIL reject_bounds: rej=%b busy=%b want 1 0", move_rejected, busy); else n_pass++;
      tick();
      n_checks++; if (curr_pos_x !== 11'd343 || busy !== 1'b0 || move_rejected !== 1'b0) $display("FAIL bounds_hold: x=%0d busy=%b rej=%b want 343 0 0", curr_pos_x, busy, move_rejected); else n_pass++;
   endtask

   task automatic test_reset_midmove();
      for (int i = 0; i < 7; i++) do_move(2'b11, 4'b0001);
      for (int i = 0; i < 6; i++) do_move(2'b01, 4'b0100);
      n_checks++; if (curr_pos_x !== 11'd455 || curr_pos_y !== 10'd146 || cell_col !== 4'd7 || cell_row !== 4'd7) $display("FAIL at_7_7: x=%0d y=%0d col=%0d row=%0d want 455 146 7 7", curr_pos_x, curr_pos_y, cell_col, cell_row); else n_pass++;
      valid_moves = 4'b1000;
      move_dir    = 2'b00;
      move_req    = 1'b1;
      tick();
      move_req = 1'b0;
      repeat (20) tick();
      n_checks++; if (curr_pos_y !== 10'd136 || busy !== 1'b1) $display("FAIL up_10_steps: y=%0d busy=%b want 136 1", curr_pos_y, busy); else n_pass++;
      rst = 1'b1;
      tick();
      n_checks++; if (curr_pos_x !== 11'd359 || curr_pos_y !== 10'd50 || move_done !== 1'b0 || cell_row !== 4'd1 || cell_col !== 4'd1) $display("FAIL midmove_reset: x=%0d y=%0d done=%b col=%0d row=%0d want 359 50 0 1 1", curr_pos_x, curr_pos_y, move_done, cell_col, cell_row); else n_pass++;
      rst = 1'b0;
      repeat (3) tick();
      n_checks++; if (busy !== 1'b0 || move_done !== 1'b0 || curr_pos_y !== 10'd50) $display("FAIL midmove_reset_idle: busy=%b done=%b y=%0d want 0 0 50", busy, move_done, curr_pos_y); else n_pass++;
   endtask

   task automatic test_req_while_busy();
      valid_moves = 4'b0101;
      move_dir    = 2'b11;
      move_req    = 1'b1;
      tick();
      move_req = 1'b0;
      repeat (4) tick();
      move_dir = 2'b01;
      move_req = 1'b1;
      tick();
      move_req = 1'b0;
      n_checks++; if (move_rejected !== 1'b0 || busy !== 1'b1) $display("FAIL busy_req: rej=%b busy=%b want 0 1", move_rejected, busy); else n_pass++;
      repeat (29) tick();
      n_checks++; if (busy !== 1'b0 || cell_col !== 4'd2 || cell_row !== 4'd1) $display("FAIL busy_req_idle: busy=%b col=%0d row=%0d want 0 2 1", busy, cell_col, cell_row); else n_pass++;
      tick();
`ifdef MOVE_QUEUE_EN
      n_checks++; if (busy !== 1'b1 || move_rejected !== 1'b0) $display("FAIL queued_start: busy=%b rej=%b want 1 0", busy, move_rejected); else n_pass++;
      repeat (31) tick();
      n_checks++; if (cell_row !== 4'd1 || curr_pos_y !== 10'd65) $display("FAIL queued_A31: row=%0d y=%0d want 1 65", cell_row, curr_pos_y); else n_pass++;
      tick();
      n_checks++; if (cell_row !== 4'd2 || curr_pos_y !== 10'd66 || move_done !== 1'b1) $display("FAIL queued_done: row=%0d y=%0d done=%b want 2 66 1", cell_row, curr_pos_y, move_done); else n_pass++;
      wait_idle();
`else
      n_checks++; if (busy !== 1'b0 || move_rejected !== 1'b0) $display("FAIL dropped_req: busy=%b rej=%b want 0 0", busy, move_rejected); else n_pass++;
      repeat (5) tick();
      n_checks++; if (busy !== 1'b0 || cell_row !== 4'd1 || curr_pos_y !== 10'd50) $display("FAIL dropped_hold: busy=%b row=%0d y=%0d want 0 1 50", busy, cell_row, curr_pos_y); else n_pass++;
`endif
   endtask

   initial begin
      rst         = 1'b1;
      move_req    = 1'b0;
      move_dir    = 2'b00;
      valid_moves = 4'b0000;
      test_reset();
      test_move_right();
      test_reject_valid();
      test_bounds();
      test_reset_midmove();
      test_req_while_busy();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
